// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: control-bundle widths, bit positions and types shared by the control unit and pipeline registers
package mips_ctrl_pkg;
   localparam int EX_W = 3;
   localparam int M_W  = 3;
   localparam int WB_W = 2;
   localparam int EX_REGDST   = 2;
   localparam int EX_ALUOP    = 1;
   localparam int EX_ALUSRC   = 0;
   localparam int M_BRANCH    = 2;
   localparam int M_MEMREAD   = 1;
   localparam int M_MEMWRITE  = 0;
   localparam int WB_REGWRITE = 1;
   localparam int WB_MEMTOREG = 0;
   localparam int CTRL_W = EX_W + M_W + WB_W;
   typedef struct packed {
      logic [EX_W-1:0] ex;
      logic [M_W-1:0]  m;
      logic [WB_W-1:0] wb;
   } ctrl_t;
   // True when a control bundle can change architectural state (memory or register file).
   function automatic logic writes_state(ctrl_t c);
      return c.m[M_MEMWRITE] | c.wb[WB_REGWRITE];
   endfunction
endpackage

// File: rtl/id_ex_stage_reg_if.sv
// id_ex_stage_reg_if: decode-side inputs and execute-side outputs of the ID/EX register
interface id_ex_stage_reg_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
);
   import mips_ctrl_pkg::*;
   logic              stall_i, flush_i, valid_i;
   logic [EX_W-1:0]   ex_i, ex_o;
   logic [M_W-1:0]    m_i, m_o;
   logic [WB_W-1:0]   wb_i, wb_o;
   logic [5:0]        funct_i, funct_o;
   logic [DATA_W-1:0] pc4_i, rd1_i, rd2_i, imm_i;
   logic [DATA_W-1:0] pc4_o, rd1_o, rd2_o, imm_o;
   logic [REG_AW-1:0] rs_i, rt_i, rd_i, rs_o, rt_o, rd_o;
   logic              valid_o;
   logic [CNT_W-1:0]  bubble_cnt_o;
   modport master (
      output stall_i, flush_i, valid_i, ex_i, m_i, wb_i, funct_i,
             pc4_i, rd1_i, rd2_i, imm_i, rs_i, rt_i, rd_i,
      input  valid_o, ex_o, m_o, wb_o, funct_o, pc4_o, rd1_o, rd2_o,
             imm_o, rs_o, rt_o, rd_o, bubble_cnt_o
   );
   modport slave (
      input  stall_i, flush_i, valid_i, ex_i, m_i, wb_i, funct_i,
             pc4_i, rd1_i, rd2_i, imm_i, rs_i, rt_i, rd_i,
      output valid_o, ex_o, m_o, wb_o, funct_o, pc4_o, rd1_o, rd2_o,
             imm_o, rs_o, rt_o, rd_o, bubble_cnt_o
   );
endinterface

// File: rtl/id_ex_stage_reg_field.sv
// pipe_field_reg: field-group register with async reset, hold and a synchronous clear that beats hold
module pipe_field_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         hold,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] val_d, val_q;
   // Clear inserts zeros even while held, otherwise hold or capture.
   always_comb val_d = clr ? '0 : hold ? val_q : d;
   // State register, cleared asynchronously.
   always_ff @(posedge clk or posedge rst)
      if (rst) val_q <= '0;
      else     val_q <= val_d;
   assign q = val_q;
endmodule

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with stall, flush and a saturating bubble counter
module id_ex_stage_reg
   import mips_ctrl_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input logic               clk,
   input logic               rst,
   id_ex_stage_reg_if.slave  bus
);
   localparam int CF_W = 1 + CTRL_W;
   localparam int DF_W = 6 + 4 * DATA_W;
   localparam int SF_W = 3 * REG_AW;
   logic             bubble;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic [CF_W-1:0]  ctrl_q;
   logic [DF_W-1:0]  data_q;
   logic [SF_W-1:0]  spec_q;
   ctrl_t            ctrl_in;
   // A bubble enters on flush, or on an unstalled edge with no real instruction; the counter saturates.
   always_comb begin
      bubble  = bus.flush_i | (~bus.stall_i & ~bus.valid_i);
      ctrl_in = '{ex: bus.ex_i, m: bus.m_i, wb: bus.wb_i};
      cnt_d   = (bubble && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
   end
   // Bubble counter register.
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   pipe_field_reg #(.W(CF_W)) u_ctrl (
      .clk(clk), .rst(rst), .hold(bus.stall_i), .clr(bubble),
      .d({1'b1, ctrl_in}), .q(ctrl_q)
   );
   pipe_field_reg #(.W(DF_W)) u_data (
      .clk(clk), .rst(rst), .hold(bus.stall_i), .clr(bubble),
      .d({bus.funct_i, bus.pc4_i, bus.rd1_i, bus.rd2_i, bus.imm_i}), .q(data_q)
   );
   pipe_field_reg #(.W(SF_W)) u_spec (
      .clk(clk), .rst(rst), .hold(bus.stall_i), .clr(bubble),
      .d({bus.rs_i, bus.rt_i, bus.rd_i}), .q(spec_q)
   );
   assign {bus.valid_o, bus.ex_o, bus.m_o, bus.wb_o} = ctrl_q;
   assign {bus.funct_o, bus.pc4_o, bus.rd1_o, bus.rd2_o, bus.imm_o} = data_q;
   assign {bus.rs_o, bus.rt_o, bus.rd_o} = spec_q;
   assign bus.bubble_cnt_o = cnt_q;
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: directed stimulus, per-cycle behavioural model compare and literal spot checks
module tb_id_ex_stage_reg;
   localparam int CNT_MAX = 15;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int errors = 0;
   int checks = 0;
   id_ex_stage_reg_if #(.DATA_W(32), .REG_AW(5), .CNT_W(4)) bus ();
   id_ex_stage_reg #(.DATA_W(32), .REG_AW(5), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   logic        m_valid;
   logic [2:0]  m_ex, m_m;
   logic [1:0]  m_wb;
   logic [5:0]  m_funct;
   logic [31:0] m_pc4, m_rd1, m_rd2, m_imm;
   logic [4:0]  m_rs, m_rt, m_rd;
   int          m_cnt;
   task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   function automatic logic [191:0] dut_vec();
      return {bus.valid_o, bus.ex_o, bus.m_o, bus.wb_o, bus.funct_o, bus.pc4_o, bus.rd1_o,
              bus.rd2_o, bus.imm_o, bus.rs_o, bus.rt_o, bus.rd_o, bus.bubble_cnt_o};
   endfunction
   function automatic logic [191:0] model_vec();
      logic [3:0] c;
      c = 4'(m_cnt);
      return {m_valid, m_ex, m_m, m_wb, m_funct, m_pc4, m_rd1, m_rd2, m_imm, m_rs, m_rt, m_rd, c};
   endfunction
   // Model: bubble zeroes everything and bumps a capped count; stall keeps; valid load copies inputs.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         {m_valid, m_ex, m_m, m_wb, m_funct, m_pc4, m_rd1, m_rd2, m_imm, m_rs, m_rt, m_rd} <= '0;
         m_cnt <= 0;
      end else if (bus.flush_i || (!bus.stall_i && !bus.valid_i)) begin
         {m_valid, m_ex, m_m, m_wb, m_funct, m_pc4, m_rd1, m_rd2, m_imm, m_rs, m_rt, m_rd} <= '0;
         m_cnt <= (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
      end else if (!bus.stall_i) begin
         m_valid <= 1'b1;
         m_ex <= bus.ex_i; m_m <= bus.m_i; m_wb <= bus.wb_i; m_funct <= bus.funct_i;
         m_pc4 <= bus.pc4_i; m_rd1 <= bus.rd1_i; m_rd2 <= bus.rd2_i; m_imm <= bus.imm_i;
         m_rs <= bus.rs_i; m_rt <= bus.rt_i; m_rd <= bus.rd_i;
      end
   end
   // Compare process: full output vector against the model, plus the bubble-has-no-side-effects invariant.
   always @(negedge clk) begin
      chk("model", dut_vec(), model_vec());
      if (!bus.valid_o) chk("bubble_ctrl_zero", {bus.ex_o, bus.m_o, bus.wb_o}, 0);
   end
   task automatic drive(input logic v, input logic st, input logic fl, input logic [2:0] ex,
                        input logic [2:0] m, input logic [1:0] wb, input logic [31:0] rd1,
                        input logic [4:0] rd);
      bus.valid_i = v; bus.stall_i = st; bus.flush_i = fl;
      bus.ex_i = ex; bus.m_i = m; bus.wb_i = wb; bus.rd1_i = rd1; bus.rd_i = rd;
      bus.funct_i = rd1[5:0] ^ 6'h2a;
      bus.pc4_i = rd1 + 32'h400;
      bus.rd2_i = ~rd1;
      bus.imm_i = {rd1[15:0], rd1[15:0]};
      bus.rs_i = rd + 5'd1;
      bus.rt_i = rd + 5'd2;
   endtask
   task automatic step();
      @(posedge clk);
      #2;
   endtask
   initial begin
      drive(0, 0, 0, 3'b000, 3'b000, 2'b00, 32'h0, 5'd0);
      #3;
      chk("reset_all_zero", dut_vec(), 0);
      step();
      rst = 1'b0;
      drive(1, 0, 0, 3'b110, 3'b000, 2'b10, 32'h0000_0005, 5'd8);
      step();
      chk("rtype_ex", bus.ex_o, 3'b110);
      chk("rtype_wb", bus.wb_o, 2'b10);
      chk("rtype_rd1", bus.rd1_o, 32'h5);
      chk("rtype_rd", bus.rd_o, 5'd8);
      chk("rtype_valid", bus.valid_o, 1'b1);
      chk("rtype_pc4", bus.pc4_o, 32'h405);
      drive(1, 1, 0, 3'b001, 3'b011, 2'b01, 32'h0000_0063, 5'd3);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_ex", bus.ex_o, 3'b110);
         chk("stall_rd1", bus.rd1_o, 32'h5);
         chk("stall_rd", bus.rd_o, 5'd8);
         chk("stall_cnt", bus.bubble_cnt_o, 4'd0);
      end
      drive(1, 1, 1, 3'b111, 3'b111, 2'b11, 32'hdead_beef, 5'd31);
      step();
      chk("flush_valid", bus.valid_o, 1'b0);
      chk("flush_ctrl", {bus.ex_o, bus.m_o, bus.wb_o}, 8'h00);
      chk("flush_rd1", bus.rd1_o, 32'h0);
      chk("flush_cnt", bus.bubble_cnt_o, 4'd1);
      drive(1, 0, 0, 3'b011, 3'b010, 2'b11, 32'h0000_1000, 5'd9);
      step();
      chk("lw_m", bus.m_o, 3'b010);
      chk("lw_valid", bus.valid_o, 1'b1);
      drive(0, 0, 0, 3'b111, 3'b111, 2'b11, 32'h1234_5678, 5'd4);
      step();
      chk("inv_ex", bus.ex_o, 3'b000);
      chk("inv_valid", bus.valid_o, 1'b0);
      chk("inv_cnt", bus.bubble_cnt_o, 4'd2);
      drive(1, 0, 0, 3'b100, 3'b001, 2'b00, 32'hffff_fff0, 5'd17);
      step();
      drive(0, 1, 0, 3'b111, 3'b100, 2'b10, 32'h0, 5'd0);
      step();
      chk("stall_no_valid_keeps", bus.m_o, 3'b001);
      chk("stall_no_valid_cnt", bus.bubble_cnt_o, 4'd2);
      drive(1, 0, 0, 3'b000, 3'b100, 2'b00, 32'h8000_0001, 5'd2);
      step();
      drive(1, 1, 0, 3'b010, 3'b010, 2'b01, 32'h5555_5555, 5'd6);
      #1;
      rst = 1'b1;
      #1;
      chk("async_rst_stall", dut_vec(), 0);
      step();
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         drive(i[0], i[1], 1, 3'b101, 3'b110, 2'b11, 32'(i), 5'(i));
         step();
         chk("sat_cnt", bus.bubble_cnt_o, (i + 1 < CNT_MAX) ? i + 1 : CNT_MAX);
      end
      chk("sat_final", bus.bubble_cnt_o, 4'hf);
      drive(0, 0, 0, 3'b000, 3'b000, 2'b00, 32'h0, 5'd0);
      step();
      chk("sat_hold", bus.bubble_cnt_o, 4'hf);
      drive(1, 0, 1, 3'b111, 3'b111, 2'b11, 32'h7, 5'd7);
      #1;
      rst = 1'b1;
      #1;
      chk("async_rst_flush", dut_vec(), 0);
      step();
      rst = 1'b0;
      drive(1, 0, 0, 3'b110, 3'b000, 2'b10, 32'h42, 5'd10);
      step();
      chk("post_rst_cnt", bus.bubble_cnt_o, 4'd0);
      chk("post_rst_rd1", bus.rd1_o, 32'h42);
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register for the 5-stage MIPS datapath.
- Captures the decode-stage control bundles EX[2:0], M[2:0] and WB[1:0], register-file read data, the sign-extended immediate, register specifiers and PC+4.
- Presents them to the execute stage one cycle later.
- Supports stall (hold), flush (bubble insertion) and counts inserted bubbles for performance debug.

Parameters:
- DATA_W, 32, width of datapath words (PC+4, read data, immediate).
- REG_AW, 5, register specifier width.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- stall_i  in  1  hold all stage contents this cycle.
- flush_i  in  1  replace the stage contents with a bubble this cycle.
- valid_i  in  1  the decode stage holds a real instruction.
- ex_i  in  3  {RegDst, ALUOp, ALUSrc}.
- m_i  in  3  {Branch, MemRead, MemWrite}.
- wb_i  in  2  {RegWrite, MemtoReg}.
- funct_i  in  6  instruction bits [5:0].
- pc4_i  in  DATA_W  PC+4 of the decoded instruction.
- rd1_i  in  DATA_W  register-file read port 1 data.
- rd2_i  in  DATA_W  register-file read port 2 data.
- imm_i  in  DATA_W  sign-extended immediate.
- rs_i, rt_i, rd_i  in  REG_AW each  register specifiers.
- valid_o  out  1  the execute stage holds a real instruction.
- ex_o, m_o, wb_o  out  3/3/2  registered control bundles.
- funct_o, pc4_o, rd1_o, rd2_o, imm_o, rs_o, rt_o, rd_o  out  same widths as inputs  registered data fields.
- bubble_cnt_o  out  CNT_W  number of bubbles inserted since reset.

Behaviour:
- Reset: asynchronous on rst high. All outputs are 0, including valid_o, all control bits and bubble_cnt_o. Release takes effect at the next rising edge.
- Latency: exactly one cycle from input to output when loading.
- Per-edge priority, highest first: flush_i, then stall_i, then load.
- flush_i=1 (regardless of stall_i):
  - valid_o, ex_o, m_o and wb_o are cleared to 0.
  - All data fields are cleared to 0.
  - bubble_cnt_o increments.
- stall_i=1, flush_i=0:
  - Every output register holds its value.
  - bubble_cnt_o is unchanged.
- Load (stall_i=0, flush_i=0):
  - If valid_i=1: all fields capture their inputs and valid_o=1.
  - If valid_i=0: a bubble is loaded. Controls and data are 0, valid_o=0, and bubble_cnt_o increments.
- Invariant: when valid_o=0, ex_o, m_o and wb_o are 0, so a bubble never writes memory or the register file.
- bubble_cnt_o saturates at all-ones and never wraps.
- Reset asserted mid-stall or mid-flush wins immediately and asynchronously.
- No combinational path from any input to any output.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - widths EX_W=3, M_W=3, WB_W=2;
  - bit-index constants EX_REGDST=2, EX_ALUOP=1, EX_ALUSRC=0, M_BRANCH=2, M_MEMREAD=1, M_MEMWRITE=0, WB_REGWRITE=1, WB_MEMTOREG=0.
- The control unit and every later pipeline register reuse this package.
- One natural sub-module, pipe_field_reg: a parameterised-width register with async reset, hold enable and synchronous clear. It is instantiated once per field group (control, data, specifiers).

Test Plan:
- Reset: rst=1 mid-run with valid outputs loaded -> all outputs 0 immediately, before the next edge; bubble_cnt_o=0.
- R-type load: valid_i=1, ex_i=3'b110, m_i=3'b000, wb_i=2'b10, rd1_i=32'h0000_0005, rd_i=5'd8 -> next edge ex_o=3'b110, wb_o=2'b10, rd1_o=5, rd_o=8, valid_o=1.
- Stall hold: after the load above, stall_i=1 for 3 cycles with changed inputs -> outputs unchanged for all 3 edges; bubble_cnt_o unchanged.
- Flush over stall: stall_i=1 and flush_i=1 together -> next edge valid_o=0, ex_o/m_o/wb_o=0, bubble_cnt_o +1.
- Invalid load: valid_i=0 with ex_i=3'b111 -> next edge ex_o=0, valid_o=0, counter +1.
- Saturation: CNT_W=4, 20 consecutive flushes -> bubble_cnt_o reaches 4'hF and stays there.
